// File: rtl/ram_rd_arb.sv
// Two-requester Avalon-MM read arbiter sharing one DDR read master, one burst in flight.
// Requester 0 has fixed priority; requester 1 is force-granted after STARVE waiting cycles.
module ram_rd_arb #(
    parameter int unsigned AW     = 29,
    parameter int unsigned BW     = 8,
    parameter int unsigned STARVE = 16
) (
    input  logic          ram_clk,
    input  logic          reset,
    input  logic [AW-1:0] a0_address,
    input  logic [BW-1:0] a0_burstcount,
    input  logic          a0_read,
    output logic          a0_waitrequest,
    output logic [63:0]   a0_readdata,
    output logic          a0_readdatavalid,
    input  logic [AW-1:0] a1_address,
    input  logic [BW-1:0] a1_burstcount,
    input  logic          a1_read,
    output logic          a1_waitrequest,
    output logic [63:0]   a1_readdata,
    output logic          a1_readdatavalid,
    output logic [AW-1:0] m_address,
    output logic [BW-1:0] m_burstcount,
    output logic          m_read,
    input  logic          m_waitrequest,
    input  logic [63:0]   m_readdata,
    input  logic          m_readdatavalid,
    output logic          err
);
    localparam int unsigned   WW       = $clog2(STARVE + 1);
    localparam logic [WW-1:0] STARVE_W = WW'(STARVE);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t        state, state_nxt;
    logic          owner;
    logic [BW-1:0] beats;
    logic [WW-1:0] wait1;
    logic          grant0, grant1;
    logic [AW-1:0] sel_address;
    logic [BW-1:0] sel_burstcount;

    always_comb begin
        state_nxt      = state;
        grant0         = 1'b0;
        grant1         = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    grant1 = a1_read && (!a0_read || wait1 >= STARVE_W);
                    grant0 = a0_read && !grant1;
                    if (grant0 || grant1) state_nxt = CMD;
                end
            end
            CMD:     if (!m_waitrequest) state_nxt = DATA;
            DATA:    if (m_readdatavalid && beats == BW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        sel_address    = grant1 ? a1_address : a0_address;
        sel_burstcount = grant1 ? a1_burstcount : a0_burstcount;
        if (sel_burstcount == '0) sel_burstcount = BW'(1);
    end

    assign a0_waitrequest   = !grant0;
    assign a1_waitrequest   = !grant1;
    assign a0_readdata      = m_readdata;
    assign a1_readdata      = m_readdata;
    // Beats are steered by owner alone: only one burst can be outstanding.
    assign a0_readdatavalid = m_readdatavalid && (state == DATA) && !owner && !reset;
    assign a1_readdatavalid = m_readdatavalid && (state == DATA) &&  owner && !reset;

    always_ff @(posedge ram_clk) begin
        if (reset) begin
            state        <= IDLE;
            m_read       <= 1'b0;
            m_address    <= '0;
            m_burstcount <= '0;
            owner        <= 1'b0;
            beats        <= '0;
            wait1        <= '0;
            err          <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant0 || grant1) begin
                m_read       <= 1'b1;
                m_address    <= sel_address;
                m_burstcount <= sel_burstcount;
                owner        <= grant1;
            end
            if (state == CMD && !m_waitrequest) begin
                m_read <= 1'b0;
                beats  <= m_burstcount;
            end
            if (state == DATA && m_readdatavalid) beats <= beats - BW'(1);
            if (state != DATA && m_readdatavalid) err <= 1'b1;
            if (a1_read && !grant1) begin
                if (wait1 < STARVE_W) wait1 <= wait1 + WW'(1);
            end else begin
                wait1 <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ram_rd_arb.sv
// Self-checking bench for ram_rd_arb: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_ram_rd_arb;
    localparam int STARVE = 16;

    logic        ram_clk = 1'b0;
    logic        reset;
    logic [28:0] a0_address, a1_address, m_address;
    logic [7:0]  a0_burstcount, a1_burstcount, m_burstcount;
    logic        a0_read, a1_read, a0_waitrequest, a1_waitrequest;
    logic [63:0] a0_readdata, a1_readdata, m_readdata;
    logic        a0_readdatavalid, a1_readdatavalid;
    logic        m_read, m_waitrequest, m_readdatavalid, err;

    ram_rd_arb #(.AW(29), .BW(8), .STARVE(STARVE)) dut (
        .ram_clk(ram_clk), .reset(reset),
        .a0_address(a0_address), .a0_burstcount(a0_burstcount), .a0_read(a0_read),
        .a0_waitrequest(a0_waitrequest), .a0_readdata(a0_readdata),
        .a0_readdatavalid(a0_readdatavalid),
        .a1_address(a1_address), .a1_burstcount(a1_burstcount), .a1_read(a1_read),
        .a1_waitrequest(a1_waitrequest), .a1_readdata(a1_readdata),
        .a1_readdatavalid(a1_readdatavalid),
        .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .err(err)
    );

    always #5 ram_clk = ~ram_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic rst; logic r0; logic [28:0] ad0; logic [7:0] bc0;
        logic r1; logic [28:0] ad1; logic [7:0] bc1;
        logic mw; logic mv; logic [63:0] md;
        logic w0; logic w1; logic v0; logic v1; logic mr;
        logic [28:0] ma; logic [7:0] mb; logic er;
    } vec_t;
    vec_t vecs[$];

    // Reference model: one outstanding burst described by plain counters.
    bit          mbusy, mcmd, mowner, merr;
    int          mleft, mstarve;
    logic [28:0] mma;
    logic [7:0]  mmb;
    bit          e_g0, e_g1, e_v0, e_v1;
    logic        last_w0, last_w1, last_v0, last_v1, last_mr, last_err;

    task automatic model_reset();
        mbusy = 0; mcmd = 0; mowner = 0; merr = 0; mleft = 0; mstarve = 0;
        mma = '0; mmb = '0;
    endtask

    // Call just after a falling edge with inputs set; returns at the next falling edge.
    task automatic cyc();
        e_g0 = 0; e_g1 = 0;
        if (!reset && !mbusy) begin
            e_g1 = a1_read && (!a0_read || mstarve >= STARVE);
            e_g0 = a0_read && !e_g1;
        end
        e_v0 = !reset && mbusy && !mcmd && m_readdatavalid && !mowner;
        e_v1 = !reset && mbusy && !mcmd && m_readdatavalid &&  mowner;
        #1;
        last_w0 = a0_waitrequest; last_w1 = a1_waitrequest;
        last_v0 = a0_readdatavalid; last_v1 = a1_readdatavalid;
        last_mr = m_read; last_err = err;
        chk("wreq0", a0_waitrequest, !e_g0);
        chk("wreq1", a1_waitrequest, !e_g1);
        chk("rdv0", a0_readdatavalid, e_v0);
        chk("rdv1", a1_readdatavalid, e_v1);
        chk("m_read", m_read, mcmd);
        chk("m_address", m_address, mma);
        chk("m_burstcount", m_burstcount, mmb);
        chk("err", err, merr);
        chk("rdata0", a0_readdata, m_readdata);
        chk("rdata1", a1_readdata, m_readdata);
        if (reset) begin
            model_reset();
        end else begin
            if (m_readdatavalid && (!mbusy || mcmd)) merr = 1;
            if (a1_read && !e_g1) mstarve = (mstarve < STARVE) ? mstarve + 1 : STARVE;
            else mstarve = 0;
            if (e_g0 || e_g1) begin
                mbusy = 1; mcmd = 1; mowner = e_g1;
                mma = e_g1 ? a1_address : a0_address;
                mmb = e_g1 ? a1_burstcount : a0_burstcount;
                if (mmb == 0) mmb = 1;
            end else if (mcmd) begin
                if (!m_waitrequest) begin mcmd = 0; mleft = int'(mmb); end
            end else if (mbusy && m_readdatavalid) begin
                mleft--;
                if (mleft == 0) mbusy = 0;
            end
        end
        @(negedge ram_clk);
    endtask

    task automatic clear_inputs();
        a0_read = 0; a1_read = 0; a0_address = '0; a1_address = '0;
        a0_burstcount = '0; a1_burstcount = '0;
        m_waitrequest = 0; m_readdatavalid = 0; m_readdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1; cyc(); reset = 0;
    endtask

    task automatic drain();
        a0_read = 0; a1_read = 0;
        for (int i = 0; i < 60 && mbusy; i++) begin
            m_waitrequest = 0;
            m_readdatavalid = mbusy && !mcmd;
            m_readdata = {$urandom(), $urandom()};
            cyc();
        end
        m_readdatavalid = 0;
        chk("drain_timeout", mbusy, 0);
    endtask

    bit          r0_on, r1_on;
    int          acc, nbeats;
    logic [6:0]  pat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        clear_inputs();
        @(negedge ram_clk); @(negedge ram_clk);

        //           rst r0 ad0    bc0 r1 ad1    bc1 mw mv md                      w0 w1 v0 v1 mr ma     mb er
        vecs.push_back('{1, 1, 'h100, 1, 0, 0,     0,  0, 0, 0,                      1, 1, 0, 0, 0, 0,     0, 0});
        vecs.push_back('{0, 1, 'h100, 1, 0, 0,     0,  0, 0, 0,                      0, 1, 0, 0, 0, 0,     0, 0});
        vecs.push_back('{0, 0, 0,     0, 0, 0,     0,  0, 0, 0,                      1, 1, 0, 0, 1, 'h100, 1, 0});
        vecs.push_back('{0, 0, 0,     0, 0, 0,     0,  0, 1, 64'hDEADBEEF01234567,  1, 1, 1, 0, 0, 'h100, 1, 0});
        vecs.push_back('{0, 1, 'h200, 1, 1, 'h300, 1,  0, 0, 0,                      0, 1, 0, 0, 0, 'h100, 1, 0});
        vecs.push_back('{0, 0, 0,     0, 1, 'h300, 1,  1, 0, 0,                      1, 1, 0, 0, 1, 'h200, 1, 0});
        vecs.push_back('{0, 0, 0,     0, 1, 'h300, 1,  0, 0, 0,                      1, 1, 0, 0, 1, 'h200, 1, 0});
        vecs.push_back('{0, 0, 0,     0, 1, 'h300, 1,  0, 1, 64'h1111,              1, 1, 1, 0, 0, 'h200, 1, 0});
        vecs.push_back('{0, 0, 0,     0, 1, 'h300, 1,  0, 0, 0,                      1, 0, 0, 0, 0, 'h200, 1, 0});
        vecs.push_back('{0, 0, 0,     0, 0, 0,     0,  0, 0, 0,                      1, 1, 0, 0, 1, 'h300, 1, 0});
        vecs.push_back('{0, 0, 0,     0, 0, 0,     0,  0, 1, 64'h2222,              1, 1, 0, 1, 0, 'h300, 1, 0});
        vecs.push_back('{0, 1, 'h400, 0, 0, 0,     0,  0, 0, 0,                      0, 1, 0, 0, 0, 'h300, 1, 0});
        vecs.push_back('{0, 0, 0,     0, 0, 0,     0,  0, 0, 0,                      1, 1, 0, 0, 1, 'h400, 1, 0});
        vecs.push_back('{0, 0, 0,     0, 0, 0,     0,  0, 0, 0,                      1, 1, 0, 0, 0, 'h400, 1, 0});
        vecs.push_back('{0, 0, 0,     0, 0, 0,     0,  0, 1, 64'h3333,              1, 1, 1, 0, 0, 'h400, 1, 0});
        vecs.push_back('{0, 0, 0,     0, 0, 0,     0,  0, 0, 0,                      1, 1, 0, 0, 0, 'h400, 1, 0});
        vecs.push_back('{0, 0, 0,     0, 0, 0,     0,  0, 1, 64'h4444,              1, 1, 0, 0, 0, 'h400, 1, 0});
        vecs.push_back('{0, 0, 0,     0, 0, 0,     0,  0, 0, 0,                      1, 1, 0, 0, 0, 'h400, 1, 1});
        vecs.push_back('{1, 1, 'h500, 2, 1, 'h600, 3,  0, 0, 0,                      1, 1, 0, 0, 0, 'h400, 1, 1});
        vecs.push_back('{0, 0, 0,     0, 0, 0,     0,  0, 0, 0,                      1, 1, 0, 0, 0, 0,     0, 0});

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            a0_read = vecs[i].r0; a0_address = vecs[i].ad0; a0_burstcount = vecs[i].bc0;
            a1_read = vecs[i].r1; a1_address = vecs[i].ad1; a1_burstcount = vecs[i].bc1;
            m_waitrequest = vecs[i].mw; m_readdatavalid = vecs[i].mv; m_readdata = vecs[i].md;
            #1;
            chk($sformatf("vec%0d_wreq0", i), a0_waitrequest, vecs[i].w0);
            chk($sformatf("vec%0d_wreq1", i), a1_waitrequest, vecs[i].w1);
            chk($sformatf("vec%0d_rdv0", i), a0_readdatavalid, vecs[i].v0);
            chk($sformatf("vec%0d_rdv1", i), a1_readdatavalid, vecs[i].v1);
            chk($sformatf("vec%0d_rdata0", i), a0_readdata, vecs[i].md);
            chk($sformatf("vec%0d_m_read", i), m_read, vecs[i].mr);
            chk($sformatf("vec%0d_m_address", i), m_address, vecs[i].ma);
            chk($sformatf("vec%0d_m_burstcount", i), m_burstcount, vecs[i].mb);
            chk($sformatf("vec%0d_err", i), err, vecs[i].er);
            @(negedge ram_clk);
        end

        // Burst of 4 for requester 1: 3 stall cycles on the command, gaps between beats.
        model_reset();
        do_reset();
        a1_read = 1; a1_address = 'h500; a1_burstcount = 4;
        cyc();
        chk("b4_accept", last_w1, 0);
        a1_read = 0;
        for (int i = 0; i < 3; i++) begin
            m_waitrequest = 1; cyc();
            chk("b4_stall_m_read", last_mr, 1);
        end
        m_waitrequest = 0; cyc();
        pat = 7'b1011001;
        nbeats = 0;
        for (int i = 0; i < 7; i++) begin
            m_readdatavalid = pat[i];
            m_readdata = {$urandom(), $urandom()};
            cyc();
            nbeats += int'(last_v1);
        end
        chk("b4_beat_count", nbeats, 4);
        m_readdatavalid = 0; a0_read = 1; a0_address = 'h510; a0_burstcount = 1;
        cyc();
        chk("b4_idle_after_last", last_w0, 0);
        drain();

        // Starvation guard: requester 0 hammers single-beat reads.
        do_reset();
        a1_read = 1; a1_address = 'h700; a1_burstcount = 1;
        a0_read = 1; a0_burstcount = 1;
        acc = -1;
        for (int c = 0; c < 200 && acc < 0; c++) begin
            a0_address = 29'('h800 + c);
            m_waitrequest = 0;
            m_readdatavalid = mbusy && !mcmd;
            m_readdata = {$urandom(), $urandom()};
            cyc();
            if (!last_w1) acc = c;
        end
        // Each requester-0 read occupies 3 cycles, so idle slots fall on multiples of 3.
        chk("starve_accept_cycle", 64'(acc), 64'(((STARVE + 2) / 3) * 3));
        drain();

        // Reset with 2 beats still pending; the late beats must only raise err.
        do_reset();
        a0_read = 1; a0_address = 'h600; a0_burstcount = 4;
        cyc();
        a0_read = 0; m_waitrequest = 0; cyc();
        m_readdatavalid = 1; cyc(); cyc();
        reset = 1; a0_read = 1; m_readdatavalid = 0;
        cyc();
        chk("rst_mid_wreq0", last_w0, 1);
        reset = 0; a0_read = 0;
        m_readdatavalid = 1; cyc();
        chk("rst_late_beat1_valid", last_v0, 0);
        chk("rst_late_m_read", last_mr, 0);
        cyc();
        chk("rst_late_beat2_valid", last_v0, 0);
        chk("rst_late_err_set", last_err, 1);
        m_readdatavalid = 0; cyc();
        chk("rst_late_err_sticky", last_err, 1);

        // Randomized traffic against the reference model.
        do_reset();
        r0_on = 0; r1_on = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!r0_on && $urandom_range(2) == 0) begin
                r0_on = 1; a0_address = 29'($urandom()); a0_burstcount = 8'($urandom_range(4));
            end else if (r0_on && $urandom_range(40) == 0) r0_on = 0;
            if (!r1_on && $urandom_range(3) == 0) begin
                r1_on = 1; a1_address = 29'($urandom()); a1_burstcount = 8'($urandom_range(4));
            end else if (r1_on && $urandom_range(40) == 0) r1_on = 0;
            a0_read = r0_on; a1_read = r1_on;
            reset = ($urandom_range(499) == 0);
            m_waitrequest = ($urandom_range(2) == 0);
            m_readdatavalid = mbusy && !mcmd && ($urandom_range(1) == 0);
            m_readdata = {$urandom(), $urandom()};
            cyc();
            if (e_g0) r0_on = 0;
            if (e_g1) r1_on = 0;
        end
        reset = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
